// File: rtl/rv32_if_fetch_if.sv
// Bundles the IF-stage bus: instruction-memory port, ID feedback and ID-facing outputs.
// The master modport is the fetch stage; slave is the surrounding ID/memory side.
interface rv32_if_fetch_if;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata;
    logic        jump_enable_in;
    logic [31:0] jump_addr_in;
    logic        lw_stall_flag_in;
    logic [31:0] lw_stall_pc_in;
    logic        halt_in;
    logic [31:0] pc_to_ID;
    logic [31:0] iw_to_ID;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, imem_rd_en, pc_to_ID, iw_to_ID, halted, misalign_err, fetch_count,
        input  imem_rdata, jump_enable_in, jump_addr_in, lw_stall_flag_in, lw_stall_pc_in,
               halt_in
    );

    modport slave (
        input  imem_addr, imem_rd_en, pc_to_ID, iw_to_ID, halted, misalign_err, fetch_count,
        output imem_rdata, jump_enable_in, jump_addr_in, lw_stall_flag_in, lw_stall_pc_in,
               halt_in
    );
endinterface

// File: rtl/rv32_if_fetch.sv
// RV32I instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem and hands
// pc/iw pairs to ID, handling jump redirects, load-use replay and EBREAK halt.
module rv32_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IW   = 32'h0000_0013,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    rv32_if_fetch_if.master   fetch_io
);
    localparam logic [31:0] Step = 32'(PC_STEP);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] count_q, count_d;
    logic        squash_q, squash_d;
    logic        halted_q, halted_d;
    logic        misalign_q, misalign_d;
    logic        rd_en;

    always_comb begin
        pc_d       = pc_q + Step;
        id_pc_d    = pc_q;
        squash_d   = 1'b0;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        rd_en      = 1'b1;

        // The word ID sees this cycle is a real delivery unless squashed.
        if (!squash_q && !halted_q) begin
            count_d = count_q + 32'd1;
        end

        if (halted_q || fetch_io.halt_in) begin
            pc_d     = pc_q;
            id_pc_d  = id_pc_q;
            squash_d = 1'b1;
            halted_d = 1'b1;
            rd_en    = 1'b0;
        end else if (fetch_io.jump_enable_in) begin
            pc_d     = {fetch_io.jump_addr_in[31:2], 2'b00};
            squash_d = 1'b1;
            if (fetch_io.jump_addr_in[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (fetch_io.lw_stall_flag_in) begin
            pc_d     = fetch_io.lw_stall_pc_in + Step;
            squash_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= RESET_PC;
            count_q    <= 32'd0;
            squash_q   <= 1'b1;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            count_q    <= count_d;
            squash_q   <= squash_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    // Squash mux sits after the memory so iw stays aligned with the registered pc.
    assign fetch_io.imem_addr    = pc_q;
    assign fetch_io.imem_rd_en   = rd_en && !reset;
    assign fetch_io.pc_to_ID     = id_pc_q;
    assign fetch_io.iw_to_ID     = squash_q ? NOP_IW : fetch_io.imem_rdata;
    assign fetch_io.halted       = halted_q;
    assign fetch_io.misalign_err = misalign_q;
    assign fetch_io.fetch_count  = count_q;
endmodule

// File: tb/tb_rv32_if_fetch.sv
// Scoreboard bench for rv32_if_fetch: the driver predicts delivered PCs, a monitor checks ID.
module tb_rv32_if_fetch;
    localparam logic [31:0] Nop = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rv32_if_fetch_if bus ();

    rv32_if_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .fetch_io (bus)
    );

    // Instruction memory: mem[a] = a ^ 0xA5A5, never equal to the NOP encoding for aligned a.
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rdata <= bus.imem_addr ^ 32'h0000_A5A5;
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_cnt;
    logic [31:0] cnt_bias;
    logic        model_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every non-NOP word presented to ID must be the next predicted fetch.
    always @(negedge clk) begin
        if (reset) begin
            model_cnt = 32'd0;
        end else if (bus.iw_to_ID !== Nop) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc %h iw %h expected none",
                         bus.pc_to_ID, bus.iw_to_ID);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("pc_to_ID", bus.pc_to_ID, e);
                check("iw_to_ID", bus.iw_to_ID, e ^ 32'h0000_A5A5);
                check("fetch_count", bus.fetch_count, model_cnt + cnt_bias);
                model_cnt = model_cnt + 32'd1;
            end
        end
    end

    // One cycle of ID feedback; called and returns at posedge+1.
    task automatic step(input bit jmp, input logic [31:0] ja, input bit stl,
                        input logic [31:0] sp);
        check("imem_addr", bus.imem_addr, model_pc);
        bus.jump_enable_in   = jmp;
        bus.jump_addr_in     = ja;
        bus.lw_stall_flag_in = stl;
        bus.lw_stall_pc_in   = sp;
        if (jmp) begin
            model_pc = {ja[31:2], 2'b00};
            if (ja[1:0] != 2'b00) model_mis = 1'b1;
        end else if (stl) begin
            model_pc = sp + 32'd4;
        end else begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        bus.jump_enable_in   = 1'b0;
        bus.lw_stall_flag_in = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rd_en_in_reset", {31'd0, bus.imem_rd_en}, 32'd0);
        end
        check("rst_pc_to_ID", bus.pc_to_ID, 32'd0);
        check("rst_iw_to_ID", bus.iw_to_ID, Nop);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
        check("rst_count", bus.fetch_count, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        exp_q.delete();
        model_pc  = 32'd0;
        model_mis = 1'b0;
        cnt_bias  = 32'd0;
        reset     = 1'b0;
    endtask

    task automatic do_halt();
        bus.halt_in = 1'b1;
        #1;
        check("halt_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
        @(posedge clk);
        #1;
        bus.halt_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("halted", {31'd0, bus.halted}, 32'd1);
            check("halted_rd_en", {31'd0, bus.imem_rd_en}, 32'd0);
            check("halted_iw", bus.iw_to_ID, Nop);
            check("halted_pc_hold", bus.imem_addr, model_pc);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] ra, rs;
        int r;
        bus.jump_enable_in   = 1'b0;
        bus.jump_addr_in     = 32'd0;
        bus.lw_stall_flag_in = 1'b0;
        bus.lw_stall_pc_in   = 32'd0;
        bus.halt_in          = 1'b0;
        bus.imem_rdata       = 32'd0;
        model_cnt            = 32'd0;
        cnt_bias             = 32'd0;

        do_reset();
        run(4);                                   // pc_q reaches 0x10
        step(1'b1, 32'h40, 1'b0, 32'd0);
        run(3);
        step(1'b0, 32'd0, 1'b1, 32'h20);          // load-use replay
        run(3);
        step(1'b1, 32'h80, 1'b1, 32'h20);         // jump beats stall
        run(2);
        step(1'b1, 32'h82, 1'b0, 32'd0);
        run(2);
        check("misalign_err", {31'd0, bus.misalign_err}, 32'd1);
        step(1'b1, 32'h20, 1'b0, 32'd0);
        run(4);                                   // pc_q reaches 0x30
        do_halt();
        check("queue_drained_halt", exp_q.size(), 32'd0);
        do_reset();
        run(3);

        // Preload the counter just below wrap.
        force dut.count_q = 32'hFFFF_FFFD;
        release dut.count_q;
        cnt_bias = 32'hFFFF_FFFD - model_cnt;
        run(6);

        step(1'b1, 32'hFFFF_FFF4, 1'b0, 32'd0);  // PC wrap at top of address space
        run(5);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            ra = $urandom;
            rs = $urandom;
            rs[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            step(r < 12, ra, (r >= 8) && (r < 20), rs);
        end
        do_halt();
        check("queue_drained_end", exp_q.size(), 32'd0);
        check("misalign_final", {31'd0, bus.misalign_err}, {31'd0, model_mis});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
